// File: rtl/stitch_pipeline_out_buffer_pkg.sv
// stitch_pkg: shared widths and defaults for the stitched pipeline output buffer.
package stitch_pkg;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 4;
    localparam int DEF_LATENCY    = 3;

    function automatic int PTR_W(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int CNT_W(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/stitch_pipeline_out_buffer_if.sv
// stitch_pipeline_out_buffer_if: producer/pipeline/consumer signals of the output buffer.
interface stitch_pipeline_out_buffer_if import stitch_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      pipe_in_valid;
    logic                      pipe_out_valid;
    logic [DATA_WIDTH-1:0]     pipe_out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_WIDTH-1:0]     out_data;
    logic [CNT_W(DEPTH)-1:0]   occupancy;
    logic                      err;

    modport slave (
        input  req_valid, pipe_out_valid, pipe_out_data, out_ready,
        output req_ready, pipe_in_valid, out_valid, out_data, occupancy, err
    );

    modport master (
        output req_valid, pipe_out_valid, pipe_out_data, out_ready,
        input  req_ready, pipe_in_valid, out_valid, out_data, occupancy, err
    );
endinterface

// File: rtl/stitch_pipeline_out_buffer_out_fifo.sv
// stitch_out_fifo: DEPTH-entry result FIFO; push and pop may coincide at any level.
module stitch_out_fifo import stitch_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  logic [DATA_WIDTH-1:0]   push_data_i,
    input  logic                    pop_ready_i,
    output logic                    valid_o,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic [CNT_W(DEPTH)-1:0] count_o,
    output logic                    overflow_o
);
    localparam int PW = PTR_W(DEPTH);
    localparam int CW = CNT_W(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full, empty, pop, wr;

    assign empty      = count_q == '0;
    assign full       = count_q == CW'(DEPTH);
    assign pop        = !empty & pop_ready_i;
    // A pop at full frees the slot the simultaneous push lands in.
    assign wr         = push_i & (!full | pop);
    assign overflow_o = push_i & full & !pop;
    assign valid_o    = !empty;
    assign data_o     = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(wr);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(wr) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr) mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/stitch_pipeline_out_buffer.sv
// stitch_pipeline_out_buffer: credit-gated admission into a no-backpressure pipeline,
// result capture FIFO, in-flight latency watchdog and sticky protocol error.
module stitch_pipeline_out_buffer import stitch_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int LATENCY    = DEF_LATENCY
) (
    input logic                        clk,
    input logic                        rst,
    stitch_pipeline_out_buffer_if.slave bus
);
    localparam int PW = PTR_W(DEPTH);
    localparam int CW = CNT_W(DEPTH);
    localparam int AW = $clog2(LATENCY + 2);
    localparam logic [AW-1:0] AGE_MAX = AW'(LATENCY + 1);

    logic [CW-1:0] reserved_q, reserved_d, inflight_q, inflight_d;
    logic [PW-1:0] slot_wr_q, slot_wr_d, slot_rd_q, slot_rd_d;
    logic [AW-1:0] age_q [DEPTH];
    logic [AW-1:0] age_d [DEPTH];
    logic          err_q, err_d;
    logic          admit, pop, unexpected, retire, timeout, overflow;

    assign bus.req_ready     = reserved_q < CW'(DEPTH);
    assign admit             = bus.req_valid & bus.req_ready;
    assign bus.pipe_in_valid = admit;
    assign pop               = bus.out_valid & bus.out_ready;
    assign unexpected        = bus.pipe_out_valid & (inflight_q == '0);
    assign retire            = bus.pipe_out_valid & !unexpected;
    // Results return in admit order, so only the oldest slot's age can expire.
    assign timeout           = (inflight_q != '0) & !bus.pipe_out_valid & (age_q[slot_rd_q] == AGE_MAX);
    assign bus.err           = err_q;

    stitch_out_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (bus.pipe_out_valid),
        .push_data_i (bus.pipe_out_data),
        .pop_ready_i (bus.out_ready),
        .valid_o     (bus.out_valid),
        .data_o      (bus.out_data),
        .count_o     (bus.occupancy),
        .overflow_o  (overflow)
    );

    always_comb begin
        reserved_d = reserved_q + CW'(admit) - CW'(pop & (reserved_q != '0));
        inflight_d = inflight_q + CW'(admit) - CW'(retire);
        slot_wr_d  = slot_wr_q + PW'(admit);
        slot_rd_d  = slot_rd_q + PW'(retire);
        for (int i = 0; i < DEPTH; i++) age_d[i] = age_q[i] + AW'(age_q[i] != AGE_MAX);
        if (admit) age_d[slot_wr_q] = AW'(1);
        err_d      = err_q | overflow | unexpected | timeout;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reserved_q <= '0;
            inflight_q <= '0;
            slot_wr_q  <= '0;
            slot_rd_q  <= '0;
            age_q      <= '{default: '0};
            err_q      <= 1'b0;
        end else begin
            reserved_q <= reserved_d;
            inflight_q <= inflight_d;
            slot_wr_q  <= slot_wr_d;
            slot_rd_q  <= slot_rd_d;
            age_q      <= age_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_stitch_pipeline_out_buffer.sv
// tb_stitch_pipeline_out_buffer: random and directed stimulus against a queue-level
// reference model; a monitor pops expected results whenever the DUT hands one over.
module tb_stitch_pipeline_out_buffer;
    localparam int DW = 32;
    localparam int D  = 4;
    localparam int L  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          kill, force_v, stream_ph;
    logic [DW-1:0] force_d, cur_x;

    stitch_pipeline_out_buffer_if #(.DATA_WIDTH(DW), .DEPTH(D)) bus ();

    stitch_pipeline_out_buffer #(.DATA_WIDTH(DW), .DEPTH(D), .LATENCY(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Pipeline stand-in: fixed latency L, computes x + 3, shares the reset.
    logic          pv [L];
    logic [DW-1:0] pd [L];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < L; i++) begin
                pv[i] <= 1'b0;
                pd[i] <= '0;
            end
        end else begin
            pv[0] <= bus.pipe_in_valid;
            pd[0] <= cur_x + 3;
            for (int i = 1; i < L; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end
    assign bus.pipe_out_valid = (pv[L-1] & !kill) | force_v;
    assign bus.pipe_out_data  = force_v ? force_d : pd[L-1];

    int            total = 0, bad = 0, cyc = 0;
    int            m_res, m_cnt;
    bit            m_err, adm, pop, push, unexp, late;
    int            adm_t [$];
    logic [DW-1:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: reservation credits, FIFO fill level, admit timestamps.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_req_ready", bus.req_ready, 1);
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_out_data", bus.out_data, 0);
            chk("rst_occupancy", bus.occupancy, 0);
            chk("rst_err", bus.err, 0);
            m_res = 0;
            m_cnt = 0;
            m_err = 0;
            exp_q.delete();
            adm_t.delete();
        end else begin
            cyc++;
            adm  = bus.req_valid && m_res < D;
            pop  = m_cnt != 0 && bus.out_ready;
            push = bus.pipe_out_valid;
            if (!m_err) begin
                chk("req_ready", bus.req_ready, m_res < D);
                chk("pipe_in_valid", bus.pipe_in_valid, adm);
            end
            chk("out_valid", bus.out_valid, m_cnt != 0);
            chk("occupancy", bus.occupancy, m_cnt);
            chk("err", bus.err, m_err);
            if (stream_ph) chk("stream_occ_le1", bus.occupancy <= 1, 1);
            unexp = push && adm_t.size() == 0;
            late  = !push && adm_t.size() != 0 && cyc - adm_t[0] > L;
            if (push && !unexp) void'(adm_t.pop_front());
            if (adm) begin
                adm_t.push_back(cyc);
                exp_q.push_back(cur_x + 3);
            end
            if (push && m_cnt == D && !pop) m_err = 1;
            else if (push) begin
                m_cnt++;
                if (force_v) exp_q.push_back(force_d);
            end
            if (pop) m_cnt--;
            if (unexp || late) m_err = 1;
            m_res = m_res + int'(adm) - int'(pop && m_res > 0);
        end
    end

    // Monitor: every handshake must deliver the oldest expected result.
    always @(negedge clk) begin
        if (rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_data: got %0h expected nothing (cycle %0d)", bus.out_data, cyc);
            end else chk("pop_data", bus.out_data, exp_q.pop_front());
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; kill = 1'b0; force_v = 1'b0; force_d = '0; stream_ph = 1'b0; cur_x = '0;
        bus.req_valid = 1'b0;
        bus.out_ready = 1'b0;
        step(3);
        rst = 1'b1;
        step(1);
        // three admits, then reset mid-stream
        bus.req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cur_x = DW'(100 + i);
            step(1);
        end
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        bus.req_valid = 1'b0;
        step(2);
        // fill with consumer stalled, one pop, one follow-up admit
        bus.req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cur_x = DW'(i);
            step(1);
        end
        bus.req_valid = 1'b0;
        step(2);
        bus.out_ready = 1'b1;
        step(1);
        bus.out_ready = 1'b0;
        bus.req_valid = 1'b1;
        cur_x = 8;
        step(2);
        bus.req_valid = 1'b0;
        bus.out_ready = 1'b1;
        step(12);
        // sustained streaming
        stream_ph = 1'b1;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cur_x = DW'(i);
            step(1);
        end
        bus.req_valid = 1'b0;
        step(L + 3);
        stream_ph = 1'b0;
        // random traffic
        for (int i = 0; i < 300; i++) begin
            bus.req_valid = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom % 4) != 0;
            cur_x = $urandom;
            step(1);
        end
        bus.req_valid = 1'b0;
        bus.out_ready = 1'b1;
        step(L + D + 3);
        chk("drain_empty", exp_q.size(), 0);
        // lost result trips the latency watchdog
        kill = 1'b1;
        bus.out_ready = 1'b0;
        bus.req_valid = 1'b1;
        cur_x = 55;
        step(1);
        bus.req_valid = 1'b0;
        step(L + 3);
        chk("watchdog_err", bus.err, 1);
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        kill = 1'b0;
        step(1);
        // unexpected pushes fill the FIFO, then push+pop at full, then overflow
        for (int i = 0; i < 4; i++) begin
            force_v = 1'b1;
            force_d = DW'(32'hA0 + i);
            step(1);
        end
        force_d = 32'hA4;
        bus.out_ready = 1'b1;
        step(1);
        force_d = 32'hA5;
        bus.out_ready = 1'b0;
        step(1);
        force_v = 1'b0;
        chk("full_err", bus.err, 1);
        bus.out_ready = 1'b1;
        step(6);
        chk("force_drain", exp_q.size(), 0);
        // reset clears storage that now holds data
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
